// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch controller and its hold buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0100_0000;
    localparam logic [31:0] PC_INCR      = 32'd4;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } insn_pc_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {insn, pc} holding register with load, clear and valid.
// Clear wins over load so a flush can never be lost.
module fetch_hold_buffer
    import fetch_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     load,
    input  logic     clear,
    input  insn_pc_t d,
    output insn_pc_t q,
    output logic     valid
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage: owns the PC, talks to imem, and drives
// the F/D pipeline register under stall and redirect.
module fetch_stage_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSN = DEF_NOP_INSN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        w_stall,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc_32,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr_32,
    input  logic        w_imem_ready,
    input  logic        w_imem_rvalid,
    input  logic [31:0] w_imem_rdata_32,
    output logic [31:0] w_dinsn_32,
    output logic [31:0] w_dpc_32,
    output logic        w_dvalid
);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  out_pc, out_pc_n;
    logic         req, accept;
    logic         fd_load, fd_bubble;
    insn_pc_t     fd_d, resp, buf_q;
    logic         buf_load, buf_clear, buf_valid;

    assign resp = '{insn: w_imem_rdata_32, pc: out_pc};

    fetch_hold_buffer u_hold (
        .clock (clock),
        .reset (reset),
        .load  (buf_load),
        .clear (buf_clear),
        .d     (resp),
        .q     (buf_q),
        .valid (buf_valid)
    );

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        out_pc_n   = out_pc;
        req        = 1'b0;
        fd_load    = 1'b0;
        fd_bubble  = 1'b0;
        fd_d       = resp;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        if (w_redirect) begin
            fetch_pc_n = word_align(w_redirect_pc_32);
            fd_bubble  = 1'b1;
            buf_clear  = 1'b1;
            // an unanswered request must be drained before refetching
            unique case (state)
                S_WAIT, S_DRAIN:
                    state_n = w_imem_rvalid ? S_REQ : S_DRAIN;
                default:
                    state_n = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    req       = 1'b1;
                    fd_bubble = ~w_stall;
                end
                S_WAIT: begin
                    unique case (1'b1)
                        w_imem_rvalid & ~w_stall: begin
                            fd_load = 1'b1;
                            req     = 1'b1;
                            state_n = S_REQ;
                        end
                        w_imem_rvalid & w_stall: begin
                            buf_load = 1'b1;
                            state_n  = S_FULL;
                        end
                        default: fd_bubble = ~w_stall;
                    endcase
                end
                S_FULL: begin
                    if (~w_stall) begin
                        fd_load   = buf_valid;
                        fd_d      = buf_q;
                        buf_clear = 1'b1;
                        state_n   = S_REQ;
                    end
                end
                S_DRAIN: begin
                    fd_bubble = ~w_stall;
                    if (w_imem_rvalid) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end

        accept = req & ~reset & w_imem_ready;
        if (accept) begin
            out_pc_n   = fetch_pc;
            fetch_pc_n = fetch_pc + PC_INCR;
            state_n    = S_WAIT;
        end
    end

    assign w_imem_req     = req & ~reset;
    assign w_imem_addr_32 = fetch_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_REQ;
            fetch_pc   <= word_align(RESET_PC);
            out_pc     <= '0;
            w_dinsn_32 <= NOP_INSN;
            w_dpc_32   <= '0;
            w_dvalid   <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            out_pc   <= out_pc_n;
            if (fd_load) begin
                w_dinsn_32 <= fd_d.insn;
                w_dpc_32   <= fd_d.pc;
                w_dvalid   <= 1'b1;
            end else if (fd_bubble) begin
                w_dinsn_32 <= NOP_INSN;
                w_dvalid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl with a transaction-level model
// of the fetch stage and a latency-programmable imem responder.
module tb_fetch_stage_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_redirect_pc_32;
    logic        w_imem_req;
    logic [31:0] w_imem_addr_32;
    logic        w_imem_ready;
    logic        w_imem_rvalid = 1'b0;
    logic [31:0] w_imem_rdata_32 = '0;
    logic [31:0] w_dinsn_32;
    logic [31:0] w_dpc_32;
    logic        w_dvalid;

    int total = 0;
    int bad   = 0;
    int lat   = 1;

    always #5 clock = ~clock;

    fetch_stage_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .w_stall          (w_stall),
        .w_redirect       (w_redirect),
        .w_redirect_pc_32 (w_redirect_pc_32),
        .w_imem_req       (w_imem_req),
        .w_imem_addr_32   (w_imem_addr_32),
        .w_imem_ready     (w_imem_ready),
        .w_imem_rvalid    (w_imem_rvalid),
        .w_imem_rdata_32  (w_imem_rdata_32),
        .w_dinsn_32       (w_dinsn_32),
        .w_dpc_32         (w_dpc_32),
        .w_dvalid         (w_dvalid)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h0100_0008) ? 32'h8C22_0004 : a;
    endfunction

    // imem responder: one outstanding request, answer after lat cycles
    int          mcnt = 0;
    logic [31:0] maddr = '0;
    always @(posedge clock) begin
        if (reset) begin
            w_imem_rvalid <= 1'b0;
            mcnt = 0;
        end else begin
            w_imem_rvalid <= 1'b0;
            if (mcnt == 1) begin
                w_imem_rvalid   <= 1'b1;
                w_imem_rdata_32 <= mem_data(maddr);
                mcnt = 0;
            end else if (mcnt > 1) begin
                mcnt--;
            end
            if (w_imem_req && w_imem_ready) begin
                maddr = w_imem_addr_32;
                if (lat <= 1) begin
                    w_imem_rvalid   <= 1'b1;
                    w_imem_rdata_32 <= mem_data(w_imem_addr_32);
                end else begin
                    mcnt = lat - 1;
                end
            end
        end
    end

    // model: F/D contents, next fetch address, in-flight/stale/held
    logic        m_init = 1'b0;
    logic        m_fdv;
    logic [31:0] m_fdi, m_fdp, m_pc, m_opc, m_hi, m_hp;
    logic        m_out, m_stale, m_held;

    function automatic logic m_req_now();
        return !reset && !w_redirect && !m_held &&
               (!m_out || (w_imem_rvalid && !m_stale && !w_stall));
    endfunction

    always @(posedge clock) begin : model
        logic acc;
        acc = m_req_now() && w_imem_ready;
        if (reset) begin
            m_init = 1'b1;
            m_fdv = 1'b0; m_fdi = 32'h0; m_fdp = 32'h0;
            m_pc = 32'h0100_0000;
            m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
        end else if (w_redirect) begin
            m_pc  = w_redirect_pc_32 & ~32'h3;
            m_fdv = 1'b0; m_fdi = 32'h0;
            m_held = 1'b0;
            if (m_out && !w_imem_rvalid) m_stale = 1'b1;
            else begin m_out = 1'b0; m_stale = 1'b0; end
        end else begin
            if (w_imem_rvalid && m_out && m_stale) begin
                m_out = 1'b0; m_stale = 1'b0;
                if (!w_stall) begin m_fdv = 1'b0; m_fdi = 32'h0; end
            end else if (w_imem_rvalid && m_out) begin
                m_out = 1'b0;
                if (w_stall) begin
                    m_held = 1'b1; m_hi = w_imem_rdata_32; m_hp = m_opc;
                end else begin
                    m_fdv = 1'b1; m_fdi = w_imem_rdata_32; m_fdp = m_opc;
                end
            end else if (m_held && !w_stall) begin
                m_held = 1'b0;
                m_fdv = 1'b1; m_fdi = m_hi; m_fdp = m_hp;
            end else if (!w_stall) begin
                m_fdv = 1'b0; m_fdi = 32'h0;
            end
            if (acc) begin
                m_out = 1'b1; m_opc = m_pc; m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clock) begin
        if (m_init) begin
            chk("req", 32'(w_imem_req), 32'(m_req_now()));
            if (w_imem_req) chk("addr", w_imem_addr_32, m_pc);
            chk("dvalid", 32'(w_dvalid), 32'(m_fdv));
            chk("dinsn", w_dinsn_32, m_fdi);
            chk("dpc", w_dpc_32, m_fdp);
            chk("stray_rvalid", 32'(w_imem_rvalid && !m_out), 32'h0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; w_stall = 1'b0; w_redirect = 1'b0;
        w_redirect_pc_32 = '0; w_imem_ready = 1'b1;
        cyc(); cyc(); @(negedge clock);
        chk("rst_dvalid", 32'(w_dvalid), 32'h0);
        chk("rst_dinsn", w_dinsn_32, 32'h0);
        chk("rst_dpc", w_dpc_32, 32'h0);
        chk("rst_req", 32'(w_imem_req), 32'h0);

        cyc(); reset = 1'b0; @(negedge clock);
        chk("c0_addr", w_imem_addr_32, 32'h0100_0000);
        cyc(); @(negedge clock);
        chk("c1_addr", w_imem_addr_32, 32'h0100_0004);
        cyc(); @(negedge clock);
        chk("c2_addr", w_imem_addr_32, 32'h0100_0008);
        chk("c2_dvalid", 32'(w_dvalid), 32'h1);
        chk("c2_dpc", w_dpc_32, 32'h0100_0000);

        cyc(); w_stall = 1'b1; @(negedge clock);
        chk("stall_req", 32'(w_imem_req), 32'h0);
        cyc(); @(negedge clock);
        chk("stall_hold_pc", w_dpc_32, 32'h0100_0004);
        cyc();
        cyc(); w_stall = 1'b0; @(negedge clock);
        chk("full_req", 32'(w_imem_req), 32'h0);
        cyc(); w_stall = 1'b1; w_imem_ready = 1'b0; @(negedge clock);
        chk("unstall_insn", w_dinsn_32, 32'h8C22_0004);
        chk("unstall_pc", w_dpc_32, 32'h0100_0008);
        chk("resume_addr", w_imem_addr_32, 32'h0100_000C);

        cyc(); w_redirect = 1'b1; w_redirect_pc_32 = 32'h0100_0043;
        w_imem_ready = 1'b1; @(negedge clock);
        chk("redir_req", 32'(w_imem_req), 32'h0);
        cyc(); w_redirect = 1'b0; w_stall = 1'b0; lat = 3; @(negedge clock);
        chk("redir_addr", w_imem_addr_32, 32'h0100_0040);
        chk("redir_dvalid", 32'(w_dvalid), 32'h0);
        chk("redir_dinsn", w_dinsn_32, 32'h0);

        cyc(); w_redirect = 1'b1; w_redirect_pc_32 = 32'h0100_0080;
        cyc(); w_redirect = 1'b0; @(negedge clock);
        chk("drain_req", 32'(w_imem_req), 32'h0);
        cyc(); lat = 1; @(negedge clock);
        chk("stale_rvalid", 32'(w_imem_rvalid), 32'h1);
        cyc(); @(negedge clock);
        chk("drain_addr", w_imem_addr_32, 32'h0100_0080);
        cyc();
        cyc(); w_stall = 1'b1; @(negedge clock);
        chk("tgt_dpc", w_dpc_32, 32'h0100_0080);
        chk("tgt_dvalid", 32'(w_dvalid), 32'h1);

        cyc(); w_redirect = 1'b1; w_redirect_pc_32 = 32'h0200_0000;
        cyc(); w_redirect = 1'b0; w_stall = 1'b0; @(negedge clock);
        chk("fullredir_dvalid", 32'(w_dvalid), 32'h0);
        chk("fullredir_addr", w_imem_addr_32, 32'h0200_0000);
        cyc();
        cyc(); @(negedge clock);
        chk("fullredir_dpc", w_dpc_32, 32'h0200_0000);

        cyc(); w_redirect = 1'b1; w_redirect_pc_32 = 32'hFFFF_FFFC;
        cyc(); w_redirect = 1'b0; @(negedge clock);
        chk("wrap_addr0", w_imem_addr_32, 32'hFFFF_FFFC);
        chk("wrap_dvalid", 32'(w_dvalid), 32'h0);
        cyc(); lat = 3; @(negedge clock);
        chk("wrap_addr1", w_imem_addr_32, 32'h0000_0000);

        cyc(); reset = 1'b1; @(negedge clock);
        chk("midrst_req", 32'(w_imem_req), 32'h0);
        chk("midrst_dpc_pre", w_dpc_32, 32'hFFFF_FFFC);
        cyc(); reset = 1'b0; lat = 1; @(negedge clock);
        chk("midrst_dvalid", 32'(w_dvalid), 32'h0);
        chk("midrst_dpc", w_dpc_32, 32'h0);
        chk("midrst_addr", w_imem_addr_32, 32'h0100_0000);
        cyc();
        cyc(); @(negedge clock);
        chk("midrst_first", w_dpc_32, 32'h0100_0000);
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
